// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the serial pin, samples each bit at mid-bit and
// delivers good bytes with a one-cycle rx_done pulse; bad stop bits raise frame_err instead.
module uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);

  generate
    if (CLKS_PER_BIT < 8) begin : g_bad_baud
      $error("uart_rx: CLKS_PER_BIT must be at least 8");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             rx_meta;
  logic             rx_s;

  // Two-flop synchroniser; resets to the idle (high) line level so no false start appears.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (cnt == CNT_MID) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shift <= {rx_s, shift[7:1]};
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          // Leaving at the stop mid-sample gives half a bit of slack for a back-to-back start edge.
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              rx_data <= shift;
              rx_done <= 1'b1;
              state   <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BRK;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        BRK: begin
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit: frames are queued as they are driven
// and checked against rx_done/frame_err pulses as they appear.
module tb_uart_rx;

  localparam int CPB = 16;

  typedef struct {
    bit         ok;
    logic [7:0] data;
    int         start;
  } sb_t;

  logic       clk;
  logic       n_rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;

  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   done_cycles[$];
  sb_t  sb_q[$];
  logic [7:0] last_good = 8'h00;
  logic prev_done = 1'b0;
  logic prev_err = 1'b0;

  uart_rx #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000)) dut (
    .clk(clk),
    .n_rst(n_rst),
    .rx(rx),
    .rx_data(rx_data),
    .rx_done(rx_done),
    .frame_err(frame_err),
    .rx_busy(rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one 8N1 frame; good frames and framing errors both get a scoreboard entry.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
    sb_t e;
    e.ok    = stop_bit;
    e.data  = data;
    e.start = cycle;
    sb_q.push_back(e);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  // Output monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    sb_t e;
    if (!n_rst) begin
      last_good = 8'h00;
      prev_done = 1'b0;
      prev_err  = 1'b0;
    end else begin
      if (rx_done && frame_err) checkOutput("done_err_overlap", 1, 0);
      if (rx_done) begin
        checkOutput("done_width", {31'd0, prev_done}, 0);
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          checkOutput("done_kind", {31'd0, e.ok}, 1);
          checkOutput("rx_data", {24'd0, rx_data}, {24'd0, e.data});
          checkOutput("done_latency", {31'd0, (cycle - e.start) inside {[154:156]}}, 1);
          last_good = e.data;
        end
        done_cnt++;
        done_cycles.push_back(cycle);
      end
      if (frame_err) begin
        checkOutput("err_width", {31'd0, prev_err}, 0);
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_frame_err", 1, 0);
        end else begin
          e = sb_q.pop_front();
          checkOutput("err_kind", {31'd0, e.ok}, 0);
          checkOutput("err_latency", {31'd0, (cycle - e.start) inside {[154:156]}}, 1);
        end
        checkOutput("err_rx_data_held", {24'd0, rx_data}, {24'd0, last_good});
        err_cnt++;
      end
      prev_done = rx_done;
      prev_err  = frame_err;
    end
  end

  initial begin
    int d0;
    int e0;
    int n0;
    rx    = 1'b1;
    n_rst = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("reset_rx_data", {24'd0, rx_data}, 0);
    checkOutput("reset_rx_done", {31'd0, rx_done}, 0);
    checkOutput("reset_frame_err", {31'd0, frame_err}, 0);
    checkOutput("reset_rx_busy", {31'd0, rx_busy}, 0);
    n_rst = 1'b1;
    repeat (8) @(negedge clk);

    // Single good byte
    applyStimulus(8'h31, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("byte31_drained", sb_q.size(), 0);
    checkOutput("byte31_done_cnt", done_cnt, 1);
    checkOutput("byte31_err_cnt", err_cnt, 0);
    checkOutput("byte31_busy_after", {31'd0, rx_busy}, 0);
    checkOutput("byte31_data_held", {24'd0, rx_data}, 32'h31);

    // Bad stop bit followed by a long break, then a good byte
    applyStimulus(8'h5A, 1'b0);
    repeat (40 * CPB) @(negedge clk);
    checkOutput("break_busy", {31'd0, rx_busy}, 1);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    checkOutput("break_err_cnt", err_cnt, 1);
    checkOutput("break_done_cnt", done_cnt, 1);
    checkOutput("break_rx_data", {24'd0, rx_data}, 32'h31);
    checkOutput("break_busy_after", {31'd0, rx_busy}, 0);
    applyStimulus(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("byte3c_drained", sb_q.size(), 0);
    checkOutput("byte3c_done_cnt", done_cnt, 2);

    // Back-to-back frames with no idle gap
    n0 = done_cycles.size();
    applyStimulus(8'hA5, 1'b1);
    applyStimulus(8'h00, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("b2b_drained", sb_q.size(), 0);
    checkOutput("b2b_done_cnt", done_cnt, 4);
    if (done_cycles.size() >= n0 + 2)
      checkOutput("b2b_spacing", done_cycles[n0+1] - done_cycles[n0], 160);
    else
      checkOutput("b2b_pulses_seen", done_cycles.size() - n0, 2);

    // Short glitch below half a bit
    d0 = done_cnt;
    e0 = err_cnt;
    repeat (2 * CPB) @(negedge clk);
    rx = 1'b0;
    repeat (6) @(negedge clk);
    rx = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!rx_busy) break;
    end
    checkOutput("glitch_busy_low", {31'd0, rx_busy}, 0);
    repeat (12 * CPB) @(negedge clk);
    checkOutput("glitch_no_done", done_cnt, d0);
    checkOutput("glitch_no_err", err_cnt, e0);

    // Reset during data bit 4 of 0xFF, then a fresh byte
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    checkOutput("abort_busy_before", {31'd0, rx_busy}, 1);
    n_rst = 1'b0;
    #1;
    checkOutput("abort_rx_data", {24'd0, rx_data}, 0);
    checkOutput("abort_busy", {31'd0, rx_busy}, 0);
    repeat (5) @(negedge clk);
    n_rst = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    checkOutput("abort_no_done", done_cnt, d0);
    checkOutput("abort_no_err", err_cnt, e0);
    checkOutput("abort_rx_data_after", {24'd0, rx_data}, 0);
    applyStimulus(8'h12, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("byte12_drained", sb_q.size(), 0);
    checkOutput("byte12_rx_data", {24'd0, rx_data}, 32'h12);

    checkOutput("total_done", done_cnt, 5);
    checkOutput("total_err", err_cnt, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
